// File: rtl/cc_checker_pkg.sv
// Shared definitions for the counter checker: FSM state encodings and default widths.
package cc_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } cc_state_e;

    localparam int unsigned CC_CNT_WIDTH = 8;
    localparam int unsigned CC_ERR_WIDTH = 8;

endpackage

// File: rtl/cc_sat_counter.sv
// Saturating error tally. inc and clr together restart the tally at one.
module cc_sat_counter #(
    parameter int unsigned ERR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_WIDTH-1:0] count
);

    logic [ERR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && clr) begin
            cnt_d = ERR_WIDTH'(1);
        end else if (inc) begin
            if (cnt_q != '1) cnt_d = cnt_q + ERR_WIDTH'(1);
        end else if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/cc_checker.sv
// Observer for an upstream enable-driven counter: shadows it with a reference
// register and records mismatches (sticky flag, pulse, tally, first value).
module cc_checker
    import cc_checker_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CC_CNT_WIDTH,
    parameter int unsigned ERR_WIDTH = CC_ERR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] count_in,
    input  logic                 arm,
    input  logic                 clear_err,
    output logic                 error,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] first_err,
    output logic [1:0]           state
);

    cc_state_e            state_q;
    logic [CNT_WIDTH-1:0] ref_q;
    logic                 error_q;
    logic                 pulse_q;
    logic [CNT_WIDTH-1:0] first_q;

    logic                 mismatch;
    logic [CNT_WIDTH-1:0] resync;
    logic [CNT_WIDTH-1:0] advance;

    // Comparison only runs while armed in TRACK or FAULT; wrap is plain modulo arithmetic.
    assign mismatch = arm && ((state_q == TRACK) || (state_q == FAULT)) && (count_in != ref_q);
    assign resync   = count_in + {{(CNT_WIDTH-1){1'b0}}, enable};
    assign advance  = ref_q + {{(CNT_WIDTH-1){1'b0}}, enable};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ref_q   <= '0;
            error_q <= 1'b0;
            pulse_q <= 1'b0;
            first_q <= '0;
        end else begin
            pulse_q <= mismatch;

            if (mismatch) begin
                error_q <= 1'b1;
                if (!error_q || clear_err) first_q <= count_in;
            end else if (clear_err) begin
                error_q <= 1'b0;
                first_q <= '0;
            end

            if (!arm) begin
                state_q <= IDLE;
                ref_q   <= resync;
            end else begin
                case (state_q)
                    IDLE: begin
                        ref_q   <= resync;
                        state_q <= TRACK;
                    end
                    TRACK: begin
                        ref_q <= mismatch ? resync : advance;
                        if (mismatch) state_q <= FAULT;
                    end
                    FAULT: begin
                        ref_q <= mismatch ? resync : advance;
                        if (!mismatch && clear_err) state_q <= TRACK;
                    end
                    default: begin
                        ref_q   <= resync;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    cc_sat_counter #(
        .ERR_WIDTH(ERR_WIDTH)
    ) u_tally (
        .clk  (clk),
        .reset(reset),
        .inc  (mismatch),
        .clr  (clear_err),
        .count(err_count)
    );

    assign error     = error_q;
    assign err_pulse = pulse_q;
    assign first_err = first_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cc_checker.sv
// Bench for cc_checker: drives a simulated upstream counter with injectable dropped increments.
module tb_cc_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       cnt_en = 1'b0;
    logic [7:0] count_in = '0;
    logic       arm = 1'b0;
    logic       clear_err = 1'b0;
    logic       error;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [7:0] first_err;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0=idle,1=tracking,2=faulted; plain integer arithmetic.
    int m_mode = 0, m_ref = 0, m_err = 0, m_pulse = 0, m_tally = 0, m_first = 0;

    cc_checker #(
        .CNT_WIDTH(8),
        .ERR_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .count_in (count_in),
        .arm      (arm),
        .clear_err(clear_err),
        .error    (error),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .first_err(first_err),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        int cin, en, event_now;
        int n_mode, n_ref, n_err, n_pulse, n_tally, n_first;
        cin = int'(count_in);
        en  = int'(enable);
        event_now = (arm && m_mode != 0 && cin != m_ref) ? 1 : 0;
        n_mode = m_mode; n_ref = m_ref; n_err = m_err;
        n_tally = m_tally; n_first = m_first;
        n_pulse = event_now;
        if (event_now != 0) begin
            n_err = 1;
            n_tally = clear_err ? 1 : ((m_tally + 1 > 255) ? 255 : m_tally + 1);
            if (m_err == 0 || clear_err) n_first = cin;
        end else if (clear_err) begin
            n_err = 0; n_tally = 0; n_first = 0;
        end
        if (!arm || m_mode == 0 || event_now != 0) n_ref = (cin + en) % 256;
        else n_ref = (m_ref + en) % 256;
        if (!arm) n_mode = 0;
        else if (m_mode == 0) n_mode = 1;
        else if (event_now != 0) n_mode = 2;
        else if (m_mode == 2 && clear_err) n_mode = 1;
        if (reset) begin
            n_mode = 0; n_ref = 0; n_err = 0; n_pulse = 0; n_tally = 0; n_first = 0;
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_ref = n_ref; m_err = n_err;
        m_pulse = n_pulse; m_tally = n_tally; m_first = n_first;
        if (reset) count_in = '0;
        else       count_in = count_in + {7'd0, cnt_en};
    endtask

    task automatic do_reset();
        reset = 1'b1; arm = 1'b0; clear_err = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        arm = 1'b1; enable = 1'b1; cnt_en = 1'b1;
        reset = 1'b1;
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", error); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b expected 0", err_pulse); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", err_count); end
        checks++; if (first_err !== 8'd0) begin errors++; $display("FAIL reset_first: got %0d expected 0", first_err); end
        reset = 1'b0; arm = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        arm = 1'b1; enable = 1'b1; cnt_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if (err_pulse !== 1'b0 || error !== 1'b0) begin
                errors++;
                $display("FAIL wrap_clean: cycle %0d count_in=%0d pulse=%0b error=%0b expected 0/0", i, count_in, err_pulse, error);
            end
        end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", err_count); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL wrap_state: got %0d expected 1", state); end
    endtask

    task automatic test_dropped_increment();
        do_reset();
        arm = 1'b1; enable = 1'b1; cnt_en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        cnt_en = 1'b0;
        step();
        cnt_en = 1'b1;
        step();
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %0b expected 1", err_pulse); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL drop_error: got %0b expected 1", error); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL drop_count: got %0d expected 1", err_count); end
        checks++; if (first_err !== 8'd10) begin errors++; $display("FAIL drop_first: got %0d expected 10", first_err); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL drop_state: got %0d expected 2", state); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (err_pulse !== 1'b0 || err_count !== 8'd1) begin
                errors++;
                $display("FAIL drop_quiet: cycle %0d pulse=%0b count=%0d expected 0/1", i, err_pulse, err_count);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] first_exp;
        first_exp = '0;
        do_reset();
        arm = 1'b1; enable = 1'b1; cnt_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 260; i++) begin
            cnt_en = 1'b0;
            step();
            cnt_en = 1'b1;
            if (i == 0) first_exp = count_in;
            step();
            step();
        end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", err_count); end
        checks++; if (first_err !== first_exp) begin errors++; $display("FAIL sat_first: got %0d expected %0d", first_err, first_exp); end
        checks++; if (int'(err_count) !== m_tally) begin errors++; $display("FAIL sat_model: got %0d expected %0d", err_count, m_tally); end
    endtask

    task automatic test_clear_collision();
        logic [7:0] first_exp;
        cnt_en = 1'b0;
        step();
        cnt_en = 1'b1;
        clear_err = 1'b1;
        first_exp = count_in;
        step();
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL coll_count: got %0d expected 1", err_count); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL coll_error: got %0b expected 1", error); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL coll_state: got %0d expected 2", state); end
        checks++; if (first_err !== first_exp) begin errors++; $display("FAIL coll_first: got %0d expected %0d", first_err, first_exp); end
        step();
        clear_err = 1'b0;
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", err_count); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL clear_error: got %0b expected 0", error); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL clear_state: got %0d expected 1", state); end
        checks++; if (first_err !== 8'd0) begin errors++; $display("FAIL clear_first: got %0d expected 0", first_err); end
    endtask

    task automatic test_disarm_reset();
        logic [7:0] first_exp;
        cnt_en = 1'b0;
        step();
        cnt_en = 1'b1;
        first_exp = count_in;
        step();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL dis_fault: got %0d expected 2", state); end
        arm = 1'b0;
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL dis_idle: got %0d expected 0", state); end
        checks++; if (error !== 1'b1 || err_count !== 8'd1 || first_err !== first_exp) begin
            errors++;
            $display("FAIL dis_keep: got error=%0b count=%0d first=%0d expected 1/1/%0d", error, err_count, first_err, first_exp);
        end
        cnt_en = 1'b0;
        count_in = 8'd77;
        step();
        cnt_en = 1'b1;
        arm = 1'b1;
        step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rearm_state: got %0d expected 1", state); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (err_pulse !== 1'b0 || err_count !== 8'd1 || state !== 2'd1) begin
                errors++;
                $display("FAIL rearm_quiet: cycle %0d pulse=%0b count=%0d state=%0d expected 0/1/1", i, err_pulse, err_count, state);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (state !== 2'd0 || error !== 1'b0 || err_pulse !== 1'b0 || err_count !== 8'd0 || first_err !== 8'd0) begin
                errors++;
                $display("FAIL mid_reset: cycle %0d state=%0d error=%0b pulse=%0b count=%0d first=%0d expected all 0",
                         i, state, error, err_pulse, err_count, first_err);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            arm       = ($urandom_range(0, 29) != 0);
            enable    = ($urandom_range(0, 3) != 0);
            cnt_en    = ($urandom_range(0, 15) == 0) ? ~enable : enable;
            clear_err = ($urandom_range(0, 9) == 0);
            step();
            if ($urandom_range(0, 63) == 0) count_in = 8'($urandom);
            checks++;
            if (int'(state) !== m_mode || int'(error) !== m_err || int'(err_pulse) !== m_pulse ||
                int'(err_count) !== m_tally || int'(first_err) !== m_first) begin
                errors++;
                $display("FAIL rnd_outputs: cycle %0d got st=%0d er=%0b pl=%0b ct=%0d fe=%0d expected st=%0d er=%0d pl=%0d ct=%0d fe=%0d",
                         i, state, error, err_pulse, err_count, first_err, m_mode, m_err, m_pulse, m_tally, m_first);
            end
        end
        reset = 1'b0; clear_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_dropped_increment();
        test_saturation();
        test_clear_collision();
        test_disarm_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
